// File: rtl/pipe_delay_pkg.sv
// Shared types and helpers for the programmable delay line.
package pipe_delay_pkg;

    localparam int DEF_DATA_W  = 2;
    localparam int DEF_MAX_DLY = 8;

    // {valid,data} word for the default-width configuration
    typedef struct packed {
        logic                  valid;
        logic [DEF_DATA_W-1:0] data;
    } stage_word_t;

    function automatic int unsigned clamp_dly(input int unsigned sel, input int unsigned max_dly);
        return (sel > max_dly) ? max_dly : sel;
    endfunction

endpackage

// File: rtl/pipe_delay_line_stage.sv
// One {valid,data} register of the delay line; clear and reset both load the idle word.
module delay_stage #(
    parameter int           W        = 3,
    parameter logic [W-1:0] RST_WORD = '0
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            q <= RST_WORD;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_delay_line.sv
// Stallable delay line: {valid,data} shifts through MAX_DLY stages, output tap chosen at run time.
module pipe_delay_line
    import pipe_delay_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                MAX_DLY = DEF_MAX_DLY,
    parameter int                DLY_W   = $clog2(MAX_DLY + 1),
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DLY_W-1:0]  dly_sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              filled,
    output logic              dly_err
);

    localparam int W = DATA_W + 1;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } word_t;

    localparam word_t IDLE_WORD = {1'b0, RST_VAL};

    word_t              stage_q [MAX_DLY];
    word_t              in_word;
    word_t              tap_word;
    logic [DLY_W-1:0]   dly_q_reg;
    logic [DLY_W-1:0]   dly_q_next;
    logic               sel_over;
    logic               dly_err_reg;
    logic [DLY_W-1:0]   fill_cnt_reg;

    assign in_word = {in_valid, in_data};

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DLY; gi++) begin : g_stage
            word_t d_word;
            if (gi == 0) begin : g_head
                assign d_word = in_word;
            end else begin : g_body
                assign d_word = stage_q[gi-1];
            end
            delay_stage #(
                .W        (W),
                .RST_WORD (IDLE_WORD)
            ) u_stage (
                .sys_clk (sys_clk),
                .sys_rst (sys_rst),
                .en      (en),
                .clr     (flush),
                .d       (d_word),
                .q       (stage_q[gi])
            );
        end
    endgenerate

    always_comb begin
        dly_q_next = DLY_W'(clamp_dly(32'(dly_sel), 32'(MAX_DLY)));
        sel_over   = (32'(dly_sel) > 32'(MAX_DLY));
    end

    // Delay select is sampled every cycle, even while stalled; any change restarts the fill count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dly_q_reg    <= '0;
            dly_err_reg  <= 1'b0;
            fill_cnt_reg <= '0;
        end else begin
            dly_q_reg   <= dly_q_next;
            dly_err_reg <= sel_over;
            if (flush || (dly_q_next != dly_q_reg)) begin
                fill_cnt_reg <= '0;
            end else if (en && (fill_cnt_reg < DLY_W'(MAX_DLY))) begin
                fill_cnt_reg <= fill_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        tap_word = IDLE_WORD;
        for (int i = 0; i < MAX_DLY; i++) begin
            if (dly_q_reg == DLY_W'(i + 1)) begin
                tap_word = stage_q[i];
            end
        end
    end

    // Reset forces the idle word even in bypass mode.
    always_comb begin
        if (sys_rst) begin
            {out_valid, out_data} = IDLE_WORD;
        end else if (dly_q_reg == '0) begin
            {out_valid, out_data} = in_word;
        end else begin
            {out_valid, out_data} = tap_word;
        end
    end

    assign filled  = (fill_cnt_reg >= dly_q_reg);
    assign dly_err = dly_err_reg;

endmodule
